// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out reader.
package piso_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} piso_state_t;

  localparam int unsigned DEF_WIDTH = 8;

endpackage

// File: rtl/bit_cnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module bit_cnt #(
  parameter int unsigned CW = 3
) (
  input  logic          clk,
  input  logic          CLRN,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_reader8.sv
// Streams an accepted parallel word out one bit per clock, then pulses done.
module piso_reader8
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             CLRN,
  input  logic [WIDTH-1:0] D,
  input  logic             vld,
  output logic             rdy,
  output logic             sout,
  output logic             sout_vld,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             head_of_d;
  logic             head_of_shifted;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             unused_cnt;

  assign rdy    = (state == IDLE);
  assign accept = rdy && vld;

  // Head bit is the one presented on sout; shifting moves the next bit into it.
  always_comb begin
    shreg_shifted   = '0;
    head_of_d       = 1'b0;
    head_of_shifted = 1'b0;
    if (MSB_FIRST) begin
      shreg_shifted   = {shreg[WIDTH-2:0], 1'b0};
      head_of_d       = D[WIDTH-1];
      head_of_shifted = shreg_shifted[WIDTH-1];
    end else begin
      shreg_shifted   = {1'b0, shreg[WIDTH-1:1]};
      head_of_d       = D[0];
      head_of_shifted = shreg_shifted[0];
    end
  end

  bit_cnt #(
    .CW(CW)
  ) u_bit_cnt (
    .clk     (clk),
    .CLRN    (CLRN),
    .load    (accept),
    .load_val(CW'(WIDTH - 1)),
    .dec     (state == SHIFT),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  assign unused_cnt = ^cnt;

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      state    <= IDLE;
      shreg    <= '0;
      sout     <= 1'b0;
      sout_vld <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state    <= SHIFT;
            shreg    <= D;
            sout     <= head_of_d;
            sout_vld <= 1'b1;
          end else begin
            sout     <= 1'b0;
            sout_vld <= 1'b0;
          end
        end
        SHIFT: begin
          shreg <= shreg_shifted;
          if (cnt_zero) begin
            state    <= DONE;
            sout     <= 1'b0;
            sout_vld <= 1'b0;
            done     <= 1'b1;
          end else begin
            sout     <= head_of_shifted;
            sout_vld <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          sout     <= 1'b0;
          sout_vld <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          sout     <= 1'b0;
          sout_vld <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_reader8.sv
// Bench for piso_reader8: queue-based model checked every cycle plus directed literal checks.
module tb_piso_reader8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [3:0] d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  wire  [2:0] rdy_a, s_a, sv_a, dn_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_reader8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
    .clk(clk), .CLRN(clrn), .D(d0), .vld(v0), .rdy(rdy_a[0]),
    .sout(s_a[0]), .sout_vld(sv_a[0]), .done(dn_a[0]));
  piso_reader8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
    .clk(clk), .CLRN(clrn), .D(d1), .vld(v1), .rdy(rdy_a[1]),
    .sout(s_a[1]), .sout_vld(sv_a[1]), .done(dn_a[1]));
  piso_reader8 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m4 (
    .clk(clk), .CLRN(clrn), .D(d2), .vld(v2), .rdy(rdy_a[2]),
    .sout(s_a[2]), .sout_vld(sv_a[2]), .done(dn_a[2]));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted word becomes a list of per-cycle outputs {sout_vld, sout, done};
  // an empty list means the reader is idle and ready.
  logic [2:0] q0[$], q1[$], q2[$];

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (q0.size() != 0) void'(q0.pop_front());
      else if (v0) begin
        for (int i = 0; i < 8; i++) q0.push_back({1'b1, d0[7-i], 1'b0});
        q0.push_back(3'b001);
      end
      if (q1.size() != 0) void'(q1.pop_front());
      else if (v1) begin
        for (int i = 0; i < 8; i++) q1.push_back({1'b1, d1[i], 1'b0});
        q1.push_back(3'b001);
      end
      if (q2.size() != 0) void'(q2.pop_front());
      else if (v2) begin
        for (int i = 0; i < 4; i++) q2.push_back({1'b1, d2[3-i], 1'b0});
        q2.push_back(3'b001);
      end
    end
  end

  function automatic logic [15:0] model_out(input int sz, input logic [2:0] front);
    return (sz == 0) ? 16'h0008 : {13'd0, front};
  endfunction

  always @(negedge clk) begin
    if (clrn) begin
      chk("cyc_m8", {12'd0, rdy_a[0], sv_a[0], s_a[0], dn_a[0]},
          model_out(q0.size(), (q0.size() != 0) ? q0[0] : 3'b000));
      chk("cyc_l8", {12'd0, rdy_a[1], sv_a[1], s_a[1], dn_a[1]},
          model_out(q1.size(), (q1.size() != 0) ? q1[0] : 3'b000));
      chk("cyc_m4", {12'd0, rdy_a[2], sv_a[2], s_a[2], dn_a[2]},
          model_out(q2.size(), (q2.size() != 0) ? q2[0] : 3'b000));
    end
  end

  task automatic wait_idle(input int idx);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rdy_a[idx]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("wait_idle_timeout", 16'd0, 16'd1);
  endtask

  // Returns at the negedge of the first bit cycle (one cycle after the accept edge).
  task automatic send(input int idx, input logic [7:0] w);
    @(negedge clk);
    case (idx)
      0: begin d0 = w; v0 = 1'b1; end
      1: begin d1 = w; v1 = 1'b1; end
      default: begin d2 = w[3:0]; v2 = 1'b1; end
    endcase
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic capture(input int idx, input int n, input bit msb,
                         output logic [15:0] w, output int vc);
    w = '0;
    vc = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (msb) w[n-1-i] = s_a[idx];
      else     w[i] = s_a[idx];
      vc += int'(sv_a[idx]);
    end
  endtask

  task automatic tail(input string name, input int idx);
    @(negedge clk);
    chk({name, "_done"}, {14'd0, sv_a[idx], dn_a[idx]}, 16'h0001);
    @(negedge clk);
    chk({name, "_after"}, {14'd0, dn_a[idx], rdy_a[idx]}, 16'h0001);
  endtask

  initial begin
    logic [15:0] w;
    int vc;

    repeat (3) @(negedge clk);
    chk("reset_m8", {12'd0, rdy_a[0], sv_a[0], s_a[0], dn_a[0]}, 16'h0008);
    clrn = 1'b1;

    // 1: MSB-first A5
    wait_idle(0);
    send(0, 8'hA5);
    capture(0, 8, 1'b1, w, vc);
    chk("t1_word", w, 16'h00A5);
    chk("t1_vcnt", 16'(vc), 16'd8);
    tail("t1", 0);

    // 2: LSB-first 01
    wait_idle(1);
    send(1, 8'h01);
    capture(1, 8, 1'b0, w, vc);
    chk("t2_word", w, 16'h0001);
    chk("t2_first", {15'd0, s_a[1]}, 16'd0);
    tail("t2", 1);

    // 3: vld held high, back-to-back FF then 00
    wait_idle(0);
    @(negedge clk);
    d0 = 8'hFF; v0 = 1'b1;
    @(negedge clk);
    d0 = 8'h00;
    capture(0, 8, 1'b1, w, vc);
    chk("t3_word1", w, 16'h00FF);
    @(negedge clk);
    chk("t3_gap1", {14'd0, sv_a[0], dn_a[0]}, 16'h0001);
    @(negedge clk);
    chk("t3_gap2", {14'd0, rdy_a[0], sv_a[0]}, 16'h0002);
    @(negedge clk);
    v0 = 1'b0;
    capture(0, 8, 1'b1, w, vc);
    chk("t3_word2", w, 16'h0000);
    chk("t3_vcnt2", 16'(vc), 16'd8);
    tail("t3", 0);

    // 4: D and vld changes during SHIFT are ignored
    wait_idle(0);
    send(0, 8'hA5);
    w = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      w[7-i] = s_a[0];
      chk("t4_rdy_low", {15'd0, rdy_a[0]}, 16'd0);
      d0 = 8'h3C; v0 = 1'b1;
    end
    chk("t4_word", w, 16'h00A5);
    @(negedge clk);
    chk("t4_done", {14'd0, rdy_a[0], dn_a[0]}, 16'h0001);
    v0 = 1'b0;
    @(negedge clk);
    chk("t4_no_second", {14'd0, rdy_a[0], sv_a[0]}, 16'h0002);

    // 5: async clear mid-word, then a fresh full word
    wait_idle(0);
    send(0, 8'hC3);
    repeat (3) @(negedge clk);
    #2 clrn = 1'b0;
    #1 chk("t5_abort", {12'd0, rdy_a[0], sv_a[0], s_a[0], dn_a[0]}, 16'h0008);
    @(negedge clk);
    chk("t5_no_done", {15'd0, dn_a[0]}, 16'd0);
    clrn = 1'b1;
    wait_idle(0);
    send(0, 8'h5A);
    capture(0, 8, 1'b1, w, vc);
    chk("t5_fresh", w, 16'h005A);
    chk("t5_vcnt", 16'(vc), 16'd8);
    tail("t5", 0);

    // 6: WIDTH=4, 1001
    wait_idle(2);
    send(2, 8'h09);
    capture(2, 4, 1'b1, w, vc);
    chk("t6_word", w, 16'h0009);
    chk("t6_vcnt", 16'(vc), 16'd4);
    tail("t6", 2);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_reader8.md
Name: piso_reader8

Overview:
Parallel-in/serial-out reader that takes the word held in an enabled data register and streams it out one bit per clock.
- Sits downstream of the datapath's 8-bit register bank and feeds a serial link or debug pin.
- Uses a valid/ready handshake on the parallel side and a bit-valid strobe plus done pulse on the serial side.

Parameters:
WIDTH, 8, word width in bits (legal range 2..16)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock; all state updates on rising edge
CLRN  input  1  asynchronous, active-low clear
D  input  WIDTH  parallel word from the source register
vld  input  1  source asserts when D holds a word to send
rdy  output  1  reader can accept a word (high only in IDLE)
sout  output  1  serial data bit
sout_vld  output  1  sout carries a valid bit this cycle
done  output  1  one-cycle pulse after the last bit of a word

Behaviour:
- Reset: CLRN low clears asynchronously, independent of clk.
  - state=IDLE, shift register=0, bit counter=0, sout=0, sout_vld=0, done=0.
  - rdy=1 because rdy is decoded from state==IDLE.
- States: IDLE, SHIFT, DONE.
  - Encoding is a package enum; all outputs are registered except rdy.
- IDLE:
  - rdy=1, sout_vld=0, sout=0.
  - On an edge with vld&rdy: load D into the shift register, set counter=WIDTH-1, go to SHIFT.
  - D is sampled only on this accept edge.
- SHIFT:
  - sout_vld=1 and sout=current head bit (MSB or LSB per MSB_FIRST).
  - Each edge shifts the register by one toward the head and decrements the counter.
  - When the counter==0 at an edge, go to DONE.
  - sout_vld stays high for exactly WIDTH consecutive cycles.
- DONE:
  - done=1 for exactly one cycle; sout_vld=0, sout=0, rdy=0.
  - Next edge goes to IDLE unconditionally.
- Latency:
  - Accept edge at cycle t.
  - Bits appear on cycles t+1..t+WIDTH.
  - done at t+WIDTH+1.
  - rdy high again at t+WIDTH+2.
  - Maximum throughput is one word per WIDTH+2 cycles.
- vld while not in IDLE: ignored. Changes on D during SHIFT/DONE do not affect the output.
- vld held high continuously: the next word is accepted on the first IDLE cycle, giving back-to-back words with a 2-cycle gap of sout_vld=0.
- Reset mid-SHIFT: transmission aborts immediately, no done pulse, and all outputs take their reset values.
- Counter width: $clog2(WIDTH); it never wraps below 0 because SHIFT exits at 0.
- No X propagation: sout is forced to 0 whenever sout_vld=0.

Decomposition:
- Shared package piso_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} piso_state_t
  - localparam DEF_WIDTH=8
- One natural sub-module: bit_cnt, a loadable down-counter with a zero flag.
  - Ports: clk, CLRN, load, load_val, dec, cnt, zero.
- The shift register and FSM stay in the top module.

Test Plan:
1. Reset, then D=8'hA5, vld=1 for one cycle, MSB_FIRST=1.
   -> sout = 1,0,1,0,0,1,0,1 on cycles t+1..t+8 with sout_vld=1; done=1 at t+9; rdy=1 at t+10.
2. MSB_FIRST=0, D=8'h01.
   -> sout = 1 then seven 0s; done pulse width exactly 1 cycle.
3. vld held high; D=8'hFF for the first word, switching to 8'h00 after its accept.
   -> eight 1s, then 2 cycles with sout_vld=0, then eight 0s; second accept at the first IDLE edge.
4. Accept 8'hA5, then change D to 8'h3C and pulse vld during SHIFT.
   -> output is still A5's bit pattern; rdy stays 0 during SHIFT/DONE; no second word starts.
5. Assert CLRN=0 asynchronously after the 4th bit of 8'hC3.
   -> sout, sout_vld and done drop to 0 immediately and rdy=1; no done pulse; the next vld starts a fresh full word.
6. WIDTH=4, D=4'b1001, MSB_FIRST=1.
   -> sout = 1,0,0,1 over 4 cycles; done at t+5; sout_vld high for exactly 4 cycles.
